// File: rtl/hyperbus_trans_arbiter.sv
// rtl/hyperbus_trans_arbiter.sv - round-robin arbiter for the shared HyperBus PHY transaction port
//
// Grants one requester at a time, forwards its transaction and chip select to
// the PHY path, and holds that grant until the completion is handed back to the
// same requester. Only one transaction is outstanding at a time.
//
// Optional feature: define HYPERBUS_ARB_TIMEOUT_EN to add a completion
// watchdog. It adds an ABORT state and a timeout_o port.
//
// Parameters: NumReq, NumChips, trans_t, TimeoutCycles
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_trans_i/req_cs_i per-requester payload and chip select
//   req_valid_i          per-requester request valid
//   req_ready_o          per-requester request accepted
//   req_done_valid_o     per-requester completion valid
//   req_done_error_o     completion error flag, shared by all requesters
//   req_done_ready_i     per-requester completion accept
//   trans_o/trans_cs_o   payload and chip select of the granted requester
//   trans_valid_o        transaction valid toward the PHY path
//   trans_ready_i        transaction accept from the PHY path
//   done_valid_i         completion valid from the PHY path
//   done_error_i         completion error from the PHY path
//   done_ready_o         completion accept toward the PHY path
//   gnt_idx_o            current or last grant index
//   busy_o               arbiter is not idle
//   timeout_o            one-cycle pulse on watchdog expiry (watchdog builds only)
module hyperbus_trans_arbiter #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned NumChips      = 2,
    parameter type         trans_t       = logic,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  trans_t                             req_trans_i [NumReq],
    input  logic [NumReq-1:0][NumChips-1:0]    req_cs_i,
    input  logic [NumReq-1:0]                  req_valid_i,
    output logic [NumReq-1:0]                  req_ready_o,
    output logic [NumReq-1:0]                  req_done_valid_o,
    output logic                               req_done_error_o,
    input  logic [NumReq-1:0]                  req_done_ready_i,
    output trans_t                             trans_o,
    output logic [NumChips-1:0]                trans_cs_o,
    output logic                               trans_valid_o,
    input  logic                               trans_ready_i,
    input  logic                               done_valid_i,
    input  logic                               done_error_i,
    output logic                               done_ready_o,
    output logic [$clog2(NumReq)-1:0]          gnt_idx_o,
`ifdef HYPERBUS_ARB_TIMEOUT_EN
    output logic                               timeout_o,
`endif
    output logic                               busy_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    if (NumReq < 2 || TimeoutCycles < 2) begin : g_param_err
        $error("hyperbus_trans_arbiter: NumReq and TimeoutCycles must both be >= 2");
    end

`ifdef HYPERBUS_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ABORT = 2'd3
    } state_e;

    localparam int unsigned CntW = $clog2(TimeoutCycles);
    logic [CntW-1:0] wdog_cnt;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;
`endif

    state_e          state;
    logic [IdxW-1:0] rr_ptr;
    logic [IdxW-1:0] arb_idx;
    logic [IdxW-1:0] cand;
    logic            arb_found;

    // Search starts one past the last completed grant, so the most recent
    // owner is considered last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= int'(NumReq); i++) begin
            cand = IdxW'((int'(rr_ptr) + i) % int'(NumReq));
            if (!arb_found && req_valid_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        trans_o          = '0;
        trans_cs_o       = '0;
        trans_valid_o    = 1'b0;
        req_ready_o      = '0;
        req_done_valid_o = '0;
        req_done_error_o = 1'b0;
        done_ready_o     = 1'b0;
        case (state)
            ST_ISSUE: begin
                trans_o                = req_trans_i[gnt_idx_o];
                trans_cs_o             = req_cs_i[gnt_idx_o];
                trans_valid_o          = 1'b1;
                req_ready_o[gnt_idx_o] = trans_ready_i;
            end
            ST_WAIT: begin
                req_done_valid_o[gnt_idx_o] = done_valid_i;
                req_done_error_o            = done_error_i;
                done_ready_o                = req_done_ready_i[gnt_idx_o];
            end
`ifdef HYPERBUS_ARB_TIMEOUT_EN
            ST_ABORT: begin
                req_done_valid_o[gnt_idx_o] = 1'b1;
                req_done_error_o            = 1'b1;
            end
`endif
            default: ;
        endcase
`ifdef HYPERBUS_ARB_TIMEOUT_EN
        // Outside WAIT any completion is stale (e.g. after an abort); sink it.
        if (state != ST_WAIT) begin
            done_ready_o = 1'b1;
        end
`endif
    end

    assign busy_o = (state != ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            rr_ptr    <= IdxW'(NumReq - 1);
            gnt_idx_o <= '0;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
            wdog_cnt  <= '0;
            timeout_o <= 1'b0;
`endif
        end else begin
`ifdef HYPERBUS_ARB_TIMEOUT_EN
            timeout_o <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        gnt_idx_o <= arb_idx;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (trans_ready_i) begin
                        state <= ST_WAIT;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
                        wdog_cnt <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (done_valid_i && req_done_ready_i[gnt_idx_o]) begin
                        rr_ptr <= gnt_idx_o;
                        state  <= ST_IDLE;
                    end
`ifdef HYPERBUS_ARB_TIMEOUT_EN
                    else if (wdog_cnt == CntW'(TimeoutCycles - 1)) begin
                        state     <= ST_ABORT;
                        timeout_o <= 1'b1;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
`endif
                end
`ifdef HYPERBUS_ARB_TIMEOUT_EN
                ST_ABORT: begin
                    if (req_done_ready_i[gnt_idx_o]) begin
                        rr_ptr <= gnt_idx_o;
                        state  <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// tb/tb_hyperbus_trans_arbiter.sv - directed self-checking bench for hyperbus_trans_arbiter
module tb_hyperbus_trans_arbiter;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [15:0]     req_trans [4];
    logic [3:0][1:0] req_cs;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [3:0]      req_done_valid;
    logic            req_done_error;
    logic [3:0]      req_done_ready;
    logic [15:0]     trans;
    logic [1:0]      trans_cs;
    logic            trans_valid;
    logic            trans_ready;
    logic            done_valid;
    logic            done_error;
    logic            done_ready;
    logic [1:0]      gnt_idx;
    logic            busy;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
    logic            timeout;
`endif

    logic [1:0] cs_tab [4];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hyperbus_trans_arbiter #(
        .NumReq        (4),
        .NumChips      (2),
        .trans_t       (logic [15:0]),
        .TimeoutCycles (16)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_trans_i      (req_trans),
        .req_cs_i         (req_cs),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_done_valid_o (req_done_valid),
        .req_done_error_o (req_done_error),
        .req_done_ready_i (req_done_ready),
        .trans_o          (trans),
        .trans_cs_o       (trans_cs),
        .trans_valid_o    (trans_valid),
        .trans_ready_i    (trans_ready),
        .done_valid_i     (done_valid),
        .done_error_i     (done_error),
        .done_ready_o     (done_ready),
        .gnt_idx_o        (gnt_idx),
`ifdef HYPERBUS_ARB_TIMEOUT_EN
        .timeout_o        (timeout),
`endif
        .busy_o           (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({trans_valid, req_ready, req_done_valid, done_ready} !== 10'b0) begin
            errors++;
            $display("FAIL reset_valid_ready: got %b want 0", {trans_valid, req_ready, req_done_valid, done_ready});
        end
        checks++;
        if ({busy, gnt_idx, req_done_error} !== 4'b0) begin
            errors++;
            $display("FAIL reset_busy_gnt_err: got %b want 0", {busy, gnt_idx, req_done_error});
        end
        checks++;
        if ({trans, trans_cs} !== 18'b0) begin
            errors++;
            $display("FAIL reset_payload: got %h want 0", {trans, trans_cs});
        end
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || trans_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got busy=%b valid=%b want 0 0", busy, trans_valid);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int grants [4];
        grants = '{default: 0};
        req_valid      = 4'b1111;
        trans_ready    = 1'b1;
        req_done_ready = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (trans_valid !== 1'b1 || gnt_idx !== 2'(k % 4)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got valid=%b gnt=%0d want 1 %0d", k, trans_valid, gnt_idx, k % 4);
            end
            checks++;
            if (trans !== 16'hA000 + 16'(k % 4) || trans_cs !== cs_tab[k % 4]) begin
                errors++;
                $display("FAIL rr_payload[%0d]: got %h/%b want %h/%b", k, trans, trans_cs, 16'hA000 + 16'(k % 4), cs_tab[k % 4]);
            end
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                errors++;
                $display("FAIL rr_req_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
            end
            grants[gnt_idx]++;
            tick();
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0 || trans_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL rr_wait_holdoff[%0d]: got ready=%b valid=%b busy=%b want 0 0 1", k, req_ready, trans_valid, busy);
            end
            tick();
            tick();
            done_valid = 1'b1;
            done_error = 1'b0;
            @(negedge clk);
            checks++;
            if (req_done_valid !== 4'(1 << (k % 4)) || done_ready !== 1'b1) begin
                errors++;
                $display("FAIL rr_done_route[%0d]: got %b/%b want %b/1", k, req_done_valid, done_ready, 4'(1 << (k % 4)));
            end
            tick();
            done_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || trans_valid !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle_gap[%0d]: got busy=%b valid=%b want 0 0", k, busy, trans_valid);
            end
            if (k == 4) req_valid = 4'b0;
            tick();
        end
        checks++;
        if (grants[0] != 2 || grants[1] != 1 || grants[2] != 1 || grants[3] != 1) begin
            errors++;
            $display("FAIL rr_fairness: got %0d %0d %0d %0d want 2 1 1 1", grants[0], grants[1], grants[2], grants[3]);
        end
    endtask

    task automatic test_stall();
        req_valid   = 4'b0100;
        trans_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (trans_valid !== 1'b1 || trans !== 16'hA002 || trans_cs !== cs_tab[2] || req_ready !== 4'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b %h/%b rdy=%b want 1 a002/%b 0000", c, trans_valid, trans, trans_cs, req_ready, cs_tab[2]);
            end
            tick();
        end
        trans_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL stall_handshake: got %b want 0100", req_ready);
        end
        tick();
        req_valid   = 4'b0;
        trans_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0 || trans_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_after: got ready=%b valid=%b want 0000 0", req_ready, trans_valid);
        end
        done_valid     = 1'b1;
        req_done_ready = 4'b1111;
        tick();
        done_valid = 1'b0;
    endtask

    task automatic test_done_error();
        req_valid   = 4'b0010;
        trans_ready = 1'b1;
        tick();
        done_valid = 1'b1;
        done_error = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt_idx !== 2'd1 || trans_valid !== 1'b1) begin
            errors++;
            $display("FAIL err_grant: got gnt=%0d valid=%b want 1 1", gnt_idx, trans_valid);
        end
`ifndef HYPERBUS_ARB_TIMEOUT_EN
        checks++;
        if (done_ready !== 1'b0 || req_done_valid !== 4'b0) begin
            errors++;
            $display("FAIL err_early_done: got ready=%b dv=%b want 0 0000", done_ready, req_done_valid);
        end
`endif
        req_done_ready = 4'b0;
        tick();
        req_valid = 4'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (req_done_valid !== 4'b0010 || req_done_error !== 1'b1 || done_ready !== 1'b0) begin
                errors++;
                $display("FAIL err_hold[%0d]: got dv=%b err=%b rdy=%b want 0010 1 0", c, req_done_valid, req_done_error, done_ready);
            end
            tick();
        end
        req_done_ready = 4'b0010;
        @(negedge clk);
        checks++;
        if (done_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_ready: got %b want 1", done_ready);
        end
        tick();
        done_valid = 1'b0;
        done_error = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_done_valid !== 4'b0) begin
            errors++;
            $display("FAIL err_idle: got busy=%b dv=%b want 0 0000", busy, req_done_valid);
        end
        req_done_ready = 4'b1111;
        tick();
    endtask

    task automatic test_reset_mid();
        req_valid   = 4'b1000;
        trans_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (gnt_idx !== 2'd3) begin
            errors++;
            $display("FAIL rst_mid_grant: got %0d want 3", gnt_idx);
        end
        tick();
        req_valid = 4'b0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt_idx !== 2'd0 || req_done_valid !== 4'b0 || trans_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: got busy=%b gnt=%0d dv=%b v=%b want 0 0 0000 0", busy, gnt_idx, req_done_valid, trans_valid);
        end
        req_valid = 4'b1111;
        tick();
        @(negedge clk);
        checks++;
        if (gnt_idx !== 2'd0 || trans_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_regrant: got gnt=%0d v=%b want 0 1", gnt_idx, trans_valid);
        end
        tick();
        req_valid  = 4'b0;
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        tick();
    endtask

`ifdef HYPERBUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        req_valid   = 4'b0100;
        trans_ready = 1'b1;
        tick();
        tick();
        req_valid      = 4'b0;
        req_done_ready = 4'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (timeout !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL to_early[%0d]: got to=%b busy=%b want 0 1", c, timeout, busy);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (timeout !== 1'b1 || req_done_valid !== 4'b0100 || req_done_error !== 1'b1) begin
            errors++;
            $display("FAIL to_abort: got to=%b dv=%b err=%b want 1 0100 1", timeout, req_done_valid, req_done_error);
        end
        done_valid = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (timeout !== 1'b0 || done_ready !== 1'b1 || req_done_valid !== 4'b0100) begin
            errors++;
            $display("FAIL to_late_done: got to=%b rdy=%b dv=%b want 0 1 0100", timeout, done_ready, req_done_valid);
        end
        req_done_ready = 4'b1111;
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_ready !== 1'b1 || req_done_valid !== 4'b0) begin
            errors++;
            $display("FAIL to_drop: got busy=%b rdy=%b dv=%b want 0 1 0000", busy, done_ready, req_done_valid);
        end
        done_valid = 1'b0;
        tick();
    endtask
`endif

    initial begin
        cs_tab = '{2'b01, 2'b10, 2'b11, 2'b01};
        for (int i = 0; i < 4; i++) begin
            req_trans[i] = 16'hA000 + 16'(i);
            req_cs[i]    = cs_tab[i];
        end
        rst_n          = 1'b0;
        req_valid      = 4'b0;
        req_done_ready = 4'b0;
        trans_ready    = 1'b0;
        done_valid     = 1'b0;
        done_error     = 1'b0;

        test_reset();
        test_round_robin();
        test_stall();
        test_done_error();
        test_reset_mid();
`ifdef HYPERBUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
